// File: rtl/phase_commutator_n_if.sv
// Control inputs and gate-drive outputs of the N-phase commutator.
// The bench drives the control inputs through the master side.
// The commutator owns the slave side and drives all outputs.
interface phase_commutator_n_if #(
    parameter int PHASES = 3
);
    logic              startI;
    logic              forceStopI;
    logic              invRotateI;
    logic              speedINCi;
    logic              speedDECi;
    logic [PHASES-1:0] hpO;
    logic [PHASES-1:0] lnO;
    logic              stepO;
    logic [3:0]        stepIdxO;
    logic              runO;
    logic              faultO;

    modport master (
        output startI, forceStopI, invRotateI, speedINCi, speedDECi,
        input  hpO, lnO, stepO, stepIdxO, runO, faultO
    );

    modport slave (
        input  startI, forceStopI, invRotateI, speedINCi, speedDECi,
        output hpO, lnO, stepO, stepIdxO, runO, faultO
    );
endinterface

// File: rtl/phase_commutator_n.sv
// N-phase six-step style commutator.
// The core is an IDLE / DEAD / DRIVE sequencer with a blanking interval between steps.
// The step period ramps under level speed requests and saturates at PERIOD_MIN and PERIOD_MAX.
// Every output is registered and is computed from the next state, so the outputs always match the state register.
module phase_commutator_n #(
    parameter int PHASES     = 3,
    parameter int DEADTIME   = 50,
    parameter int PERIOD_W   = 20,
    parameter int PERIOD_MIN = 50000,
    parameter int PERIOD_MAX = 600000,
    parameter int RAMP_STEP  = 2000
) (
    input  logic                clk50mhzI,
    input  logic                nRstI,
    phase_commutator_n_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DEAD  = 2'd1,
        ST_DRIVE = 2'd2
    } state_t;

    // A single counter times both intervals, so it must be wide enough for either one.
    localparam int DT_W  = $clog2(DEADTIME + 1);
    localparam int CNT_W = (PERIOD_W > DT_W) ? PERIOD_W : DT_W;
    // Saturation arithmetic is done wide enough that neither the sum nor the difference can wrap.
    localparam int EXT_W = 34;

    localparam logic [CNT_W-1:0]    DEAD_LAST = CNT_W'(DEADTIME - 1);
    localparam logic [3:0]          IDX_LAST  = 4'(2 * PHASES - 1);
    localparam logic [PHASES-1:0]   ONE_HOT   = PHASES'(1);
    localparam logic [PERIOD_W-1:0] P_MIN     = PERIOD_W'(PERIOD_MIN);
    localparam logic [PERIOD_W-1:0] P_MAX     = PERIOD_W'(PERIOD_MAX);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [3:0]          idx_q, idx_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [PHASES-1:0]   hp_q, hp_d;
    logic [PHASES-1:0]   ln_q, ln_d;
    logic                step_q, step_d;
    logic                run_q, run_d;
    logic                fault_q, fault_d;
    logic                stop;
    logic [CNT_W-1:0]    drive_last;

    // Shorten the period by one ramp step, clamped at PERIOD_MIN.
    function automatic logic [PERIOD_W-1:0] sat_faster(input logic [PERIOD_W-1:0] p);
        logic [EXT_W-1:0] px;
        logic [EXT_W-1:0] lim;
        px  = EXT_W'(p);
        lim = EXT_W'(PERIOD_MIN) + EXT_W'(RAMP_STEP);
        if (px <= lim) return P_MIN;
        return PERIOD_W'(px - EXT_W'(RAMP_STEP));
    endfunction

    // Lengthen the period by one ramp step, clamped at PERIOD_MAX.
    function automatic logic [PERIOD_W-1:0] sat_slower(input logic [PERIOD_W-1:0] p);
        logic [EXT_W-1:0] sum;
        sum = EXT_W'(p) + EXT_W'(RAMP_STEP);
        if (sum >= EXT_W'(PERIOD_MAX)) return P_MAX;
        return PERIOD_W'(sum);
    endfunction

    // Next step index, wrapping in both directions.
    function automatic logic [3:0] step_next(input logic [3:0] k, input logic rev);
        if (rev) return (k == 4'd0) ? IDX_LAST : k - 4'd1;
        return (k == IDX_LAST) ? 4'd0 : k + 4'd1;
    endfunction

    // The high side of step k is phase k/2.
    function automatic logic [PHASES-1:0] high_pattern(input logic [3:0] k);
        return ONE_HOT << k[3:1];
    endfunction

    // The low side of step k is phase (k/2 + 1 + k%2) mod PHASES.
    // The sum is at most PHASES+1, so a single conditional subtract replaces the modulo.
    function automatic logic [PHASES-1:0] low_pattern(input logic [3:0] k);
        logic [3:0] l;
        l = {1'b0, k[3:1]} + 4'd1 + {3'b000, k[0]};
        if (l >= 4'(PHASES)) l = l - 4'(PHASES);
        return ~(ONE_HOT << l);
    endfunction

    assign stop       = bus.forceStopI || !bus.startI;
    assign drive_last = CNT_W'(period_q) - CNT_W'(1);

    // Sequencer next state, interval timing, step advance, period ramp and next output values.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        period_d = period_q;
        step_d   = 1'b0;
        hp_d     = '0;
        ln_d     = '1;
        case (state_q)
            ST_IDLE: begin
                if (bus.startI && !bus.forceStopI) begin
                    state_d = ST_DEAD;
                    cnt_d   = '0;
                end
            end
            ST_DEAD: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DEAD_LAST) begin
                    state_d = ST_DRIVE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DRIVE: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == drive_last) begin
                    state_d = ST_DEAD;
                    cnt_d   = '0;
                    step_d  = 1'b1;
                    idx_d   = step_next(idx_q, bus.invRotateI);
                    case ({bus.speedINCi, bus.speedDECi})
                        2'b10:   period_d = sat_faster(period_q);
                        2'b01:   period_d = sat_slower(period_q);
                        default: period_d = period_q;
                    endcase
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        run_d = (state_d != ST_IDLE);
        if (state_d == ST_DRIVE) begin
            hp_d = high_pattern(idx_d);
            ln_d = low_pattern(idx_d);
        end
        fault_d = fault_q | (|(hp_d & ~ln_d));
    end

    // Sequencer state, interval counter, step index and period.
    always_ff @(posedge clk50mhzI or negedge nRstI) begin
        if (!nRstI) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            idx_q    <= 4'd0;
            period_q <= P_MAX;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            period_q <= period_d;
        end
    end

    // Registered gate drive and status outputs; the fault flag is sticky until reset.
    always_ff @(posedge clk50mhzI or negedge nRstI) begin
        if (!nRstI) begin
            hp_q    <= '0;
            ln_q    <= '1;
            step_q  <= 1'b0;
            run_q   <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            hp_q    <= hp_d;
            ln_q    <= ln_d;
            step_q  <= step_d;
            run_q   <= run_d;
            fault_q <= fault_d;
        end
    end

    assign bus.hpO      = hp_q;
    assign bus.lnO      = ln_q;
    assign bus.stepO    = step_q;
    assign bus.stepIdxO = idx_q;
    assign bus.runO     = run_q;
    assign bus.faultO   = fault_q;

endmodule

// File: tb/tb_phase_commutator_n.sv
// Bench for phase_commutator_n with small timing parameters.
// A behavioural model predicts every output on every cycle. Directed checks cover reset,
// stepping order, the speed ramp, force stop and a mid-interval reset.
module tb_phase_commutator_n;

    localparam int PH   = 3;
    localparam int DT   = 4;
    localparam int PW   = 20;
    localparam int PMIN = 8;
    localparam int PMAX = 20;
    localparam int RS   = 4;
    localparam int OW   = 2 * PH + 7;

    logic clk;
    logic nRst;
    int   total;
    int   bad;

    phase_commutator_n_if #(.PHASES(PH)) bus ();

    phase_commutator_n #(
        .PHASES    (PH),
        .DEADTIME  (DT),
        .PERIOD_W  (PW),
        .PERIOD_MIN(PMIN),
        .PERIOD_MAX(PMAX),
        .RAMP_STEP (RS)
    ) dut (
        .clk50mhzI(clk),
        .nRstI    (nRst),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Model state: mode 0 idle, 1 blanking, 2 driving; left = cycles remaining in the interval.
    int   m_mode;
    int   m_left;
    int   m_k;
    int   m_period;
    logic m_step;

    int         exp_len [13] = '{20, 16, 12, 8, 8, 12, 16, 20, 20, 20, 16, 16, 16};
    logic [1:0] ramp_req[13] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01,
                                 2'b01, 2'b01, 2'b10, 2'b11, 2'b11, 2'b00};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode   = 0;
        m_left   = 0;
        m_k      = 0;
        m_period = PMAX;
        m_step   = 1'b0;
    endtask

    task automatic model_step();
        m_step = 1'b0;
        if (m_mode == 0) begin
            if (bus.startI && !bus.forceStopI) begin
                m_mode = 1;
                m_left = DT;
            end
        end else if (bus.forceStopI || !bus.startI) begin
            m_mode = 0;
        end else begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                if (m_mode == 1) begin
                    m_mode = 2;
                    m_left = m_period;
                end else begin
                    m_mode = 1;
                    m_left = DT;
                    m_step = 1'b1;
                    if (bus.invRotateI) m_k = (m_k + 2 * PH - 1) % (2 * PH);
                    else                m_k = (m_k + 1) % (2 * PH);
                    if (bus.speedINCi && !bus.speedDECi)
                        m_period = (m_period - RS < PMIN) ? PMIN : m_period - RS;
                    else if (bus.speedDECi && !bus.speedINCi)
                        m_period = (m_period + RS > PMAX) ? PMAX : m_period + RS;
                end
            end
        end
    endtask

    function automatic logic [OW-1:0] model_outs();
        logic [PH-1:0] hp;
        logic [PH-1:0] ln;
        int            h;
        int            l;
        h  = m_k / 2;
        l  = (h + 1 + m_k % 2) % PH;
        hp = '0;
        ln = '1;
        if (m_mode == 2) begin
            hp[h] = 1'b1;
            ln[l] = 1'b0;
        end
        return {hp, ln, m_step, 4'(m_k), (m_mode != 0), 1'b0};
    endfunction

    function automatic logic [OW-1:0] dut_outs();
        return {bus.hpO, bus.lnO, bus.stepO, bus.stepIdxO, bus.runO, bus.faultO};
    endfunction

    // One clock: the model consumes the inputs at the edge, outputs are compared at the falling edge.
    task automatic tick();
        @(posedge clk);
        if (!nRst) model_reset();
        else       model_step();
        @(negedge clk);
        chk("outs", 32'(dut_outs()), 32'(model_outs()));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Wait for the next drive interval, apply the speed requests at its start, then measure its length.
    task automatic drive_len(input logic inc, input logic dec, output int len);
        int guard;
        guard = 0;
        while (bus.hpO == '0 && guard < 200) begin
            tick();
            guard++;
        end
        bus.speedINCi = inc;
        bus.speedDECi = dec;
        len = 0;
        while (bus.hpO != '0 && len < 200) begin
            tick();
            len++;
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_hp"},  32'(bus.hpO),      0);
        chk({tag, "_ln"},  32'(bus.lnO),      7);
        chk({tag, "_stp"}, 32'(bus.stepO),    0);
        chk({tag, "_idx"}, 32'(bus.stepIdxO), 0);
        chk({tag, "_run"}, 32'(bus.runO),     0);
        chk({tag, "_flt"}, 32'(bus.faultO),   0);
    endtask

    task automatic hard_reset(input logic inv);
        @(negedge clk);
        nRst = 1'b0;
        model_reset();
        bus.startI     = 1'b1;
        bus.forceStopI = 1'b0;
        bus.invRotateI = inv;
        bus.speedINCi  = 1'b0;
        bus.speedDECi  = 1'b0;
        tick();
        nRst = 1'b1;
    endtask

    initial begin
        int len;
        total = 0;
        bad   = 0;
        model_reset();
        nRst           = 1'b1;
        bus.startI     = 1'b0;
        bus.forceStopI = 1'b0;
        bus.invRotateI = 1'b0;
        bus.speedINCi  = 1'b0;
        bus.speedDECi  = 1'b0;
        #5 nRst = 1'b0;
        tick();
        tick();
        chk_reset_vals("rst");

        // Forward stepping straight out of reset.
        nRst       = 1'b1;
        bus.startI = 1'b1;
        run(1);
        chk("fwd_dead_run", 32'(bus.runO), 1);
        chk("fwd_dead_hp",  32'(bus.hpO),  0);
        run(4);
        chk("fwd_s0_hp",  32'(bus.hpO),      1);
        chk("fwd_s0_ln",  32'(bus.lnO),      5);
        chk("fwd_s0_idx", 32'(bus.stepIdxO), 0);
        run(19);
        chk("fwd_s0_end_hp", 32'(bus.hpO), 1);
        run(1);
        chk("fwd_b1_hp",  32'(bus.hpO),      0);
        chk("fwd_b1_stp", 32'(bus.stepO),    1);
        chk("fwd_b1_idx", 32'(bus.stepIdxO), 1);
        run(4);
        chk("fwd_s1_hp", 32'(bus.hpO), 1);
        chk("fwd_s1_ln", 32'(bus.lnO), 3);
        run(24);
        chk("fwd_s2_hp",  32'(bus.hpO),      2);
        chk("fwd_s2_ln",  32'(bus.lnO),      3);
        chk("fwd_s2_idx", 32'(bus.stepIdxO), 2);
        run(92);
        chk("fwd_wrap_idx", 32'(bus.stepIdxO), 0);
        chk("fwd_wrap_stp", 32'(bus.stepO),    1);

        // Reverse stepping: first boundary wraps 0 -> 5.
        hard_reset(1'b1);
        run(25);
        chk("rev_idx", 32'(bus.stepIdxO), 5);
        chk("rev_stp", 32'(bus.stepO),    1);
        run(4);
        chk("rev_s5_hp", 32'(bus.hpO), 4);
        chk("rev_s5_ln", 32'(bus.lnO), 5);

        // One-cycle force stop in the middle of a drive interval.
        run(6);
        bus.forceStopI = 1'b1;
        run(1);
        chk("fs_hp",  32'(bus.hpO),      0);
        chk("fs_ln",  32'(bus.lnO),      7);
        chk("fs_run", 32'(bus.runO),     0);
        chk("fs_idx", 32'(bus.stepIdxO), 5);
        bus.forceStopI = 1'b0;
        run(1);
        chk("fs_dead_run", 32'(bus.runO), 1);
        chk("fs_dead_hp",  32'(bus.hpO),  0);
        run(4);
        chk("fs_drv_hp",  32'(bus.hpO),      4);
        chk("fs_drv_idx", 32'(bus.stepIdxO), 5);

        // Speed ramp: requests applied at each drive start shape the following drive.
        bus.invRotateI = 1'b0;
        for (int i = 0; i < 13; i++) begin
            drive_len(ramp_req[i][1], ramp_req[i][0], len);
            chk($sformatf("ramp_len%0d", i), 32'(len), 32'(exp_len[i]));
        end
        bus.speedINCi = 1'b0;
        bus.speedDECi = 1'b0;

        // Reset in the middle of a blanking interval restores the reset period.
        run(1);
        chk("rd_in_dead", 32'(bus.runO), 1);
        nRst = 1'b0;
        #1;
        chk_reset_vals("rd");
        model_reset();
        tick();
        nRst = 1'b1;
        drive_len(1'b0, 1'b0, len);
        chk("rd_len", 32'(len), 20);

        // Randomized stimulus against the model.
        for (int i = 0; i < 3000; i++) begin
            bus.startI     = ($urandom_range(99) < 96);
            bus.forceStopI = ($urandom_range(99) < 2);
            if ($urandom_range(99) < 5) bus.invRotateI = ~bus.invRotateI;
            bus.speedINCi  = ($urandom_range(3) == 0);
            bus.speedDECi  = ($urandom_range(3) == 0);
            if ($urandom_range(999) < 3) begin
                nRst = 1'b0;
                model_reset();
            end else begin
                nRst = 1'b1;
            end
            tick();
        end
        chk("fault_end", 32'(bus.faultO), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
